// File: rtl/parity_scrub_pkg.sv
// Shared types and the parity check used by the scrub engine.
// A word is bad when its recomputed parity disagrees with the stored bit.
package parity_scrub_pkg;

   // Data is zero-extended to this width before the XOR reduction.
   // Zero padding leaves the parity unchanged, so DATA_W may be at most 64.
   localparam int MAX_DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } scan_state_e;

   function automatic logic par_mismatch(input logic [MAX_DATA_W-1:0] data,
                                         input logic                  par,
                                         input logic                  odd);
      return (^data) ^ par ^ odd;
   endfunction

endpackage

// File: rtl/parity_scrub_engine_bank.sv
// One storage bank: synchronous write and a registered read of {data, par}.
// The storage has no reset; a word is undefined until it has been written.
module parity_bank #(
   parameter  int DATA_W  = 8,
   parameter  int DEPTH   = 8,
   localparam int WORD_AW = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [WORD_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0]  wdata_i,
   input  logic               wpar_i,
   input  logic [WORD_AW-1:0] raddr_i,
   output logic [DATA_W-1:0]  rd_data_o,
   output logic               rd_par_o
);

   logic [DATA_W:0] mem_q [DEPTH];
   logic [DATA_W:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= {wdata_i, wpar_i};
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rd_data_o = rdata_q[DATA_W:1];
   assign rd_par_o  = rdata_q[0];

endmodule

// File: rtl/parity_scrub_engine.sv
// Parity scrub engine: writable banked storage plus a one-pass scan that
// checks every word's stored parity and records count and first failure.
//
// state | meaning
// IDLE  | writes accepted, waiting for start
// SCAN  | issuing pointer reads, one per cycle
// DRAIN | checking the last word read
// DONE  | one-cycle done pulse, results frozen
module parity_scrub_engine
   import parity_scrub_pkg::*;
#(
   parameter  int DATA_W     = 8,
   parameter  int DEPTH      = 8,
   parameter  int BANKS      = 2,
   parameter  int ODD_PARITY = 0,
   localparam int WORD_AW    = $clog2(DEPTH),
   localparam int BANK_AW    = $clog2(BANKS),
   localparam int AW         = BANK_AW + WORD_AW,
   localparam int N          = BANKS * DEPTH,
   localparam int CNT_W      = $clog2(N + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_par,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err_valid,
   output logic [AW-1:0]     err_addr,
   output logic [CNT_W-1:0]  err_count,
   output logic              first_err_valid,
   output logic [AW-1:0]     first_err_addr
);

   scan_state_e       state_q;
   logic [AW-1:0]     ptr_q, ptr_d;
   logic              rd_vld_q;
   logic [AW-1:0]     rd_addr_q;
   logic              busy_q, done_q, err_valid_q, first_err_valid_q;
   logic [AW-1:0]     err_addr_q, first_err_addr_q;
   logic [CNT_W-1:0]  err_count_q;

   logic [DATA_W-1:0] bank_data [BANKS];
   logic [BANKS-1:0]  bank_par;
   logic [BANK_AW-1:0] sel_bank;
   logic              in_idle;
   logic              last_issue;
   logic              chk_mm;

   assign in_idle    = (state_q == IDLE);
   assign last_issue = (ptr_q == AW'(N - 1));

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      parity_bank #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_bank (
         .clk       (clk),
         .we_i      (in_idle && wr_en && (wr_addr[AW-1:WORD_AW] == BANK_AW'(b))),
         .waddr_i   (wr_addr[WORD_AW-1:0]),
         .wdata_i   (wr_data),
         .wpar_i    (wr_par),
         .raddr_i   (ptr_q[WORD_AW-1:0]),
         .rd_data_o (bank_data[b]),
         .rd_par_o  (bank_par[b])
      );
   end

   // Every bank reads the same word; the registered pointer picks the bank.
   assign sel_bank = rd_addr_q[AW-1:WORD_AW];
   assign chk_mm   = par_mismatch(MAX_DATA_W'(bank_data[sel_bank]),
                                  bank_par[sel_bank], ODD_PARITY != 0);

   always_comb begin
      ptr_d = ptr_q;
      if (in_idle && start) begin
         ptr_d = '0;
      end else if (state_q == SCAN && !last_issue) begin
         ptr_d = ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= IDLE;
         ptr_q             <= '0;
         rd_vld_q          <= 1'b0;
         rd_addr_q         <= '0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         err_valid_q       <= 1'b0;
         err_addr_q        <= '0;
         err_count_q       <= '0;
         first_err_valid_q <= 1'b0;
         first_err_addr_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         rd_vld_q    <= (state_q == SCAN);
         rd_addr_q   <= ptr_q;
         done_q      <= 1'b0;
         err_valid_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q           <= SCAN;
                  busy_q            <= 1'b1;
                  err_count_q       <= '0;
                  first_err_valid_q <= 1'b0;
                  first_err_addr_q  <= '0;
               end
            end
            SCAN: begin
               if (last_issue) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase

         // A check is never pending in IDLE, so it cannot race the clear above.
         if (rd_vld_q && chk_mm) begin
            err_valid_q <= 1'b1;
            err_addr_q  <= rd_addr_q;
            err_count_q <= err_count_q + CNT_W'(1);
            if (!first_err_valid_q) begin
               first_err_valid_q <= 1'b1;
               first_err_addr_q  <= rd_addr_q;
            end
         end
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign err_valid       = err_valid_q;
   assign err_addr        = err_addr_q;
   assign err_count       = err_count_q;
   assign first_err_valid = first_err_valid_q;
   assign first_err_addr  = first_err_addr_q;

endmodule

// File: doc/parity_scrub_engine.md
# parity_scrub_engine

Parametrised memory-integrity engine: holds `BANKS` banks of `DEPTH` words, each `DATA_W` bits wide, with one stored parity bit per word. On command it sweeps every location with an internal address counter and checks the stored parity against the recomputed parity. It counts mismatches, flags each failing word, and records the first failing address. It supersedes the fixed two-bank, 8-word, 8-bit fetch/parity-check path by adding writable storage, selectable parity sense and an autonomous scan with a start/done handshake.

## Interface
Parameters:
- `DATA_W`, default 8: data word width, ≥1.
- `DEPTH`, default 8: words per bank; power of two, ≥2.
- `BANKS`, default 2: bank count; power of two, ≥2.
- `ODD_PARITY`, default 0:
  - 0: the stored bit equals the XOR of the data (even overall parity).
  - 1: the stored bit equals the inverse of that XOR.
- Derived:
  - `WORD_AW = $clog2(DEPTH)`
  - `BANK_AW = $clog2(BANKS)`
  - `AW = BANK_AW + WORD_AW`
  - `N = BANKS*DEPTH`
  - `CNT_W = $clog2(N+1)`

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `wr_en` in 1: write strobe.
- `wr_addr` in AW: write address; `{bank, word}`, with the bank in the MSBs.
- `wr_data` in DATA_W: write data.
- `wr_par` in 1: stored parity bit written with the data.
- `start` in 1: scan request.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse when the scan completes.
- `err_valid` out 1: one-cycle pulse per failing word.
- `err_addr` out AW: address of the failing word; qualified by `err_valid`.
- `err_count` out CNT_W: mismatch count for the last or current scan.
- `first_err_valid` out 1: at least one mismatch in this scan.
- `first_err_addr` out AW: lowest failing address in this scan.

## Operation
FSM states: IDLE, SCAN, DRAIN, DONE.
- **IDLE**
  - `wr_en`=1 writes `wr_data`/`wr_par` at `wr_addr` on the clock edge.
  - `start`=1 does the following on the same edge:
    - clears `err_count`, `first_err_valid` and `first_err_addr`;
    - sets the scan pointer to 0;
    - moves to SCAN.
  - If `start` and `wr_en` are both high, the write commits first and the scan sees the new word.
- **SCAN**
  - Issues pointer address p to every bank's registered read port each cycle, then increments p.
  - When p = N-1 has been issued, moves to DRAIN. p does not wrap into a second pass.
- **DRAIN**: one cycle that checks the last word read, then moves to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- Check stage runs one cycle after each read:
  - The bank is selected by the registered pointer MSBs.
  - mismatch = `^data ^ par ^ ODD_PARITY`.
  - On mismatch:
    - `err_valid`=1 and `err_addr`=address of the checked word;
    - `err_count` increments;
    - if `first_err_valid`=0, capture `first_err_addr` and set `first_err_valid`.
- `err_count` cannot overflow because CNT_W holds N; no saturation logic.
- In SCAN/DRAIN/DONE:
  - `wr_en` is ignored; no write occurs.
  - `start` is ignored; there is no queued restart.
- Results hold after DONE until the next `start`.
- `busy` = 1 in SCAN, DRAIN and DONE; 0 in IDLE.
- Reset:
  - State goes to IDLE, the pointer to 0, and all outputs to 0.
  - This includes `busy`, `done`, `err_valid`, `err_addr`, `err_count`, `first_err_valid` and `first_err_addr`.
  - Storage contents are not reset; they are undefined until written.
  - Reset mid-scan aborts immediately. Partial results are discarded and no `done` is produced.

## Timing
- `start` sampled at edge 0:
  - `busy`=1 from edge 0 through edge N+1;
  - reads are issued at edges 1..N;
  - `err_valid` can be high after edges 2..N+1;
  - `done`=1 after edge N+1;
  - `busy`=0 and IDLE after edge N+2.
- Start-to-done latency is N+1 cycles. Back-to-back scans are possible with `start` on the cycle after `done`: a new scan every N+2 cycles.
- Read latency is 1 cycle and check latency 1 cycle. There are no combinational paths from inputs to outputs.
- A write takes effect at the edge and is visible to a read issued on the next cycle.

## Structure
- Package `parity_scrub_pkg` contains:
  - the state enum (IDLE/SCAN/DRAIN/DONE);
  - function `par_mismatch(data, par, odd)`.
- Sub-module `parity_bank` (parameters `DATA_W`, `DEPTH`) is instantiated `BANKS` times with a generate loop. Each instance has:
  - a synchronous write;
  - a registered read of {data, par};
  - its write enable gated by the bank-field decode and IDLE.
- The top level holds the FSM, pointer, pipeline address register, bank read mux and error bookkeeping.

## Test plan
1. **Clean scan.** Defaults, ODD_PARITY=0. Write all 16 words with correct parity (e.g. `8'h1F` with `par`=1), then pulse `start`. Required: `done` exactly 17 cycles after `start`, `err_count`=0, `first_err_valid`=0, no `err_valid`.
2. **Injected errors.** Corrupt parity at addresses 5 and 12. Required:
   - `err_valid` with `err_addr`=5 at cycle 7 and `err_addr`=12 at cycle 14 after `start`;
   - `err_count`=2, `first_err_addr`=5.
3. **Odd-parity variant.** ODD_PARITY=1. Store `8'h00` with `par`=1 everywhere. Required: `err_count`=0. Flipping one bit at address 15 gives `err_count`=1 and `first_err_addr`=15.
4. **Ignored requests.** Assert `wr_en` at address 3 with bad parity, and re-assert `start`, both mid-scan. Required: no write occurs, a single `done`, and a rescan shows address 3 unchanged.
5. **Reset mid-scan.** Assert `rst` at cycle 6 of a scan. Required: all outputs 0 asynchronously, no `done`, stored data intact. A following scan gives the full correct result.
6. **Scaled configuration.** DATA_W=16, DEPTH=32, BANKS=4, with all 128 words bad. Required: `err_count`=128 without overflow (CNT_W=8), `first_err_addr`=0, `done` at cycle 129.
